// File: rtl/hwpe_stream_tcdm_decoupler.sv
// hwpe_stream_tcdm_decoupler: request/response FIFO pair that decouples a streamer TCDM port from mux stalls
module hwpe_stream_tcdm_decoupler #(
    parameter int unsigned REQ_FIFO_DEPTH  = 2,
    parameter int unsigned RESP_FIFO_DEPTH = 4,
    localparam int unsigned CW = $clog2(RESP_FIFO_DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          tcdm_slave_req,
    input  logic [31:0]   tcdm_slave_add,
    input  logic          tcdm_slave_wen,
    input  logic [3:0]    tcdm_slave_be,
    input  logic [31:0]   tcdm_slave_data,
    output logic          tcdm_slave_gnt,
    output logic [31:0]   tcdm_slave_r_data,
    output logic          tcdm_slave_r_valid,
    output logic          tcdm_master_req,
    output logic [31:0]   tcdm_master_add,
    output logic          tcdm_master_wen,
    output logic [3:0]    tcdm_master_be,
    output logic [31:0]   tcdm_master_data,
    input  logic          tcdm_master_gnt,
    input  logic [31:0]   tcdm_master_r_data,
    input  logic          tcdm_master_r_valid,
    output logic [CW-1:0] outstanding_o,
    output logic          idle_o
);
    localparam int unsigned RW = $clog2(REQ_FIFO_DEPTH);
    localparam int unsigned PW = $clog2(RESP_FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    req_t          req_mem [REQ_FIFO_DEPTH];
    logic [31:0]   resp_mem [RESP_FIFO_DEPTH];
    logic [RW-1:0] req_wr, req_rd;
    logic [RW:0]   req_cnt;
    logic [PW-1:0] resp_wr, resp_rd;
    logic [PW:0]   resp_cnt;
    logic          inflight, req_empty, req_full, resp_empty;
    logic          req_push, req_pop, resp_push, resp_pop;

    assign req_empty  = req_cnt == '0;
    assign req_full   = req_cnt == (RW+1)'(REQ_FIFO_DEPTH);
    assign resp_empty = resp_cnt == '0;

    // Credit check keeps the response FIFO from ever overflowing
    assign tcdm_slave_gnt  = tcdm_slave_req & ~req_full & (outstanding_o < CW'(RESP_FIFO_DEPTH)) & ~clear_i;
    assign tcdm_master_req = ~req_empty & ~clear_i;
    assign req_push  = tcdm_slave_gnt;
    assign req_pop   = tcdm_master_req & tcdm_master_gnt;
    assign resp_push = inflight & tcdm_master_r_valid & ~clear_i;
    assign resp_pop  = ~resp_empty;

    assign tcdm_slave_r_valid = ~resp_empty;
    assign tcdm_slave_r_data  = resp_empty ? '0 : resp_mem[resp_rd];
    assign {tcdm_master_add, tcdm_master_wen, tcdm_master_be, tcdm_master_data} = req_empty ? '0 : req_mem[req_rd];
    assign idle_o = (outstanding_o == '0) & req_empty & resp_empty;

    always_ff @(posedge clk_i) begin
        if (req_push)
            req_mem[req_wr] <= '{tcdm_slave_add, tcdm_slave_wen, tcdm_slave_be, tcdm_slave_data};
        if (resp_push)
            resp_mem[resp_wr] <= tcdm_master_r_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_wr        <= '0;
            req_rd        <= '0;
            req_cnt       <= '0;
            resp_wr       <= '0;
            resp_rd       <= '0;
            resp_cnt      <= '0;
            inflight      <= 1'b0;
            outstanding_o <= '0;
        end else if (clear_i) begin
            req_wr        <= '0;
            req_rd        <= '0;
            req_cnt       <= '0;
            resp_wr       <= '0;
            resp_rd       <= '0;
            resp_cnt      <= '0;
            inflight      <= 1'b0;
            outstanding_o <= '0;
        end else begin
            if (req_push)
                req_wr <= req_wr + RW'(1);
            if (req_pop)
                req_rd <= req_rd + RW'(1);
            req_cnt <= req_cnt + (RW+1)'(req_push) - (RW+1)'(req_pop);
            if (resp_push)
                resp_wr <= resp_wr + PW'(1);
            if (resp_pop)
                resp_rd <= resp_rd + PW'(1);
            resp_cnt      <= resp_cnt + (PW+1)'(resp_push) - (PW+1)'(resp_pop);
            inflight      <= req_pop;
            outstanding_o <= outstanding_o + CW'(req_push) - CW'(resp_pop);
        end
    end
endmodule

// File: tb/tb_hwpe_stream_tcdm_decoupler.sv
// tb_hwpe_stream_tcdm_decoupler: directed scenario tests against a fixed-latency mux model
module tb_hwpe_stream_tcdm_decoupler;
    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic        s_req = 1'b0, s_wen = 1'b1, s_gnt, s_rvalid;
    logic [31:0] s_add = '0, s_data = '0, s_rdata;
    logic [3:0]  s_be = 4'hF;
    logic        m_req, m_wen, m_gnt = 1'b0, mv, spur = 1'b0;
    logic [31:0] m_add, m_data, md, mux_off = 32'h1000;
    logic [3:0]  m_be;
    logic [2:0]  outstanding;
    logic        idle;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    hwpe_stream_tcdm_decoupler dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .tcdm_slave_req(s_req), .tcdm_slave_add(s_add), .tcdm_slave_wen(s_wen),
        .tcdm_slave_be(s_be), .tcdm_slave_data(s_data), .tcdm_slave_gnt(s_gnt),
        .tcdm_slave_r_data(s_rdata), .tcdm_slave_r_valid(s_rvalid),
        .tcdm_master_req(m_req), .tcdm_master_add(m_add), .tcdm_master_wen(m_wen),
        .tcdm_master_be(m_be), .tcdm_master_data(m_data), .tcdm_master_gnt(m_gnt),
        .tcdm_master_r_data(md), .tcdm_master_r_valid(mv | spur),
        .outstanding_o(outstanding), .idle_o(idle)
    );

    // Mux model: answers every handshake one cycle later with add + mux_off
    logic mv_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_q <= 1'b0;
            md   <= '0;
        end else begin
            mv_q <= m_req & m_gnt;
            md   <= m_add + mux_off;
        end
    end
    assign mv = mv_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        m_gnt = 1'b1;
        s_req = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) tick();
        tick();
    endtask

    task automatic test_reset;
        tick(); tick();
        #1;
        total++; if (m_req !== 1'b0 || m_add !== 32'h0) begin bad++; $display("FAIL rst_master: req=%b add=%h want 0/0", m_req, m_add); end
        total++; if (s_gnt !== 1'b0 || s_rvalid !== 1'b0 || s_rdata !== 32'h0) begin bad++; $display("FAIL rst_slave: gnt=%b rv=%b rd=%h want 0", s_gnt, s_rvalid, s_rdata); end
        total++; if (outstanding !== 3'd0 || idle !== 1'b1) begin bad++; $display("FAIL rst_state: out=%0d idle=%b want 0/1", outstanding, idle); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        mux_off = 32'hCAFDFF01;
        s_req = 1'b1; s_add = 32'h100; s_wen = 1'b1; m_gnt = 1'b0;
        #1;
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL sr_gnt: got %b want 1", s_gnt); end
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        #1;
        total++; if (m_req !== 1'b1 || m_add !== 32'h100) begin bad++; $display("FAIL sr_mreq: req=%b add=%h want 1/100", m_req, m_add); end
        total++; if (outstanding !== 3'd1 || idle !== 1'b0) begin bad++; $display("FAIL sr_out1: out=%0d idle=%b want 1/0", outstanding, idle); end
        tick();
        #1;
        total++; if (s_rvalid !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL sr_early: rv=%b mreq=%b want 0/0", s_rvalid, m_req); end
        tick();
        #1;
        total++; if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL sr_resp: rv=%b rd=%h want 1/cafe0001", s_rvalid, s_rdata); end
        tick();
        #1;
        total++; if (outstanding !== 3'd0 || idle !== 1'b1 || s_rvalid !== 1'b0) begin bad++; $display("FAIL sr_done: out=%0d idle=%b rv=%b want 0/1/0", outstanding, idle, s_rvalid); end
        m_gnt = 1'b0;
        mux_off = 32'h1000;
        tick();
    endtask

    task automatic test_back_pressure;
        m_gnt = 1'b0; s_req = 1'b1; s_add = 32'h200;
        #1;
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL bp_gnt0: got %b want 1", s_gnt); end
        tick();
        s_add = 32'h204;
        #1;
        total++; if (s_gnt !== 1'b1) begin bad++; $display("FAIL bp_gnt1: got %b want 1", s_gnt); end
        tick();
        s_add = 32'h208;
        #1;
        total++; if (s_gnt !== 1'b0 || outstanding !== 3'd2) begin bad++; $display("FAIL bp_full: gnt=%b out=%0d want 0/2", s_gnt, outstanding); end
        tick();
        m_gnt = 1'b1;
        #1;
        total++; if (s_gnt !== 1'b0 || m_add !== 32'h200) begin bad++; $display("FAIL bp_nofall: gnt=%b add=%h want 0/200", s_gnt, m_add); end
        tick();
        #1;
        total++; if (s_gnt !== 1'b1 || m_add !== 32'h204) begin bad++; $display("FAIL bp_second: gnt=%b add=%h want 1/204", s_gnt, m_add); end
        tick();
        s_req = 1'b0;
        #1;
        total++; if (m_req !== 1'b1 || m_add !== 32'h208) begin bad++; $display("FAIL bp_third: req=%b add=%h want 1/208", m_req, m_add); end
        wait_idle();
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL bp_idle: got %b want 1", idle); end
    endtask

    task automatic test_credit;
        int n = 0, k = 0, fr = -1, g5 = -1;
        logic [11:0] gv = '0;
        m_gnt = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s_req = n < 5;
            s_add = 32'h300 + 32'(4 * n);
            #1;
            if (s_gnt) begin gv[c] = 1'b1; n++; if (n == 5) g5 = c; end
            if (s_rvalid) begin
                if (fr < 0) fr = c;
                total++; if (s_rdata !== 32'h1300 + 32'(4 * k)) begin bad++; $display("FAIL cr_data%0d: got %h want %h", k, s_rdata, 32'h1300 + 32'(4 * k)); end
                k++;
            end
            tick();
        end
        total++; if (gv !== 12'b0000_0001_1111) begin bad++; $display("FAIL cr_grants: got %b want 000000011111", gv); end
        total++; if (fr !== 3 || g5 !== fr + 1) begin bad++; $display("FAIL cr_fifth: first_rv=%0d fifth_gnt=%0d want 3/4", fr, g5); end
        total++; if (k !== 5 || idle !== 1'b1) begin bad++; $display("FAIL cr_count: resp=%0d idle=%b want 5/1", k, idle); end
    endtask

    task automatic test_ordering;
        int pat [6] = '{1, 0, 1, 1, 0, 1};
        logic [31:0] got [4];
        int n = 0, k = 0;
        for (int c = 0; c < 24 && k < 4; c++) begin
            s_req = n < 4;
            s_add = 32'(4 * n);
            m_gnt = c < 6 ? pat[c][0] : 1'b1;
            #1;
            if (s_gnt) n++;
            if (s_rvalid) begin got[k] = s_rdata; k++; end
            tick();
        end
        s_req = 1'b0;
        total++; if (k !== 4) begin bad++; $display("FAIL ord_count: got %0d want 4", k); end
        for (int i = 0; i < k; i++) begin
            total++; if (got[i] !== 32'h1000 + 32'(4 * i)) begin bad++; $display("FAIL ord_resp%0d: got %h want %h", i, got[i], 32'h1000 + 32'(4 * i)); end
        end
        wait_idle();
    endtask

    task automatic test_write;
        int k = 0;
        m_gnt = 1'b0; s_req = 1'b1; s_add = 32'h400; s_wen = 1'b0; s_be = 4'hF; s_data = 32'hDEADBEEF;
        tick();
        s_req = 1'b0; s_wen = 1'b1; s_data = '0;
        #1;
        total++; if (m_req !== 1'b1 || m_wen !== 1'b0 || m_be !== 4'hF || m_data !== 32'hDEADBEEF || m_add !== 32'h400) begin
            bad++; $display("FAIL wr_fields: req=%b wen=%b be=%h data=%h add=%h want 1/0/f/deadbeef/400", m_req, m_wen, m_be, m_data, m_add);
        end
        m_gnt = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            #1;
            if (s_rvalid) k++;
            tick();
        end
        total++; if (k !== 1 || idle !== 1'b1) begin bad++; $display("FAIL wr_resp: resp=%0d idle=%b want 1/1", k, idle); end
    endtask

    task automatic test_clear;
        int k = 0;
        m_gnt = 1'b0; s_req = 1'b1; s_add = 32'h500;
        tick();
        s_add = 32'h504;
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        #1;
        total++; if (m_req !== 1'b1 || m_add !== 32'h500) begin bad++; $display("FAIL cl_hs: req=%b add=%h want 1/500", m_req, m_add); end
        tick();
        clear = 1'b1; s_req = 1'b1; s_add = 32'h508;
        #1;
        total++; if (m_req !== 1'b0 || s_gnt !== 1'b0) begin bad++; $display("FAIL cl_force: mreq=%b gnt=%b want 0/0", m_req, s_gnt); end
        tick();
        clear = 1'b0; s_req = 1'b0; spur = 1'b1;
        #1;
        total++; if (m_req !== 1'b0 || outstanding !== 3'd0 || idle !== 1'b1) begin bad++; $display("FAIL cl_after: mreq=%b out=%0d idle=%b want 0/0/1", m_req, outstanding, idle); end
        tick();
        spur = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (s_rvalid) k++;
            tick();
        end
        total++; if (k !== 0 || idle !== 1'b1) begin bad++; $display("FAIL cl_drop: resp=%0d idle=%b want 0/1", k, idle); end
    endtask

    task automatic test_async_reset;
        int k = 0;
        m_gnt = 1'b0; s_req = 1'b1; s_add = 32'h600;
        tick();
        s_req = 1'b0; m_gnt = 1'b1;
        #1;
        total++; if (m_req !== 1'b1 || outstanding !== 3'd1) begin bad++; $display("FAIL ar_pre: mreq=%b out=%0d want 1/1", m_req, outstanding); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (m_req !== 1'b0 || m_add !== 32'h0 || outstanding !== 3'd0 || idle !== 1'b1) begin
            bad++; $display("FAIL ar_now: mreq=%b add=%h out=%0d idle=%b want 0/0/0/1", m_req, m_add, outstanding, idle);
        end
        tick();
        rst_n = 1'b1; m_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (s_rvalid || m_req) k++;
            tick();
        end
        total++; if (k !== 0) begin bad++; $display("FAIL ar_replay: got %0d activity cycles want 0", k); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_pressure();
        test_credit();
        test_ordering();
        test_write();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
